// File: rtl/pipeline_decode_pkg.sv
// Shared MIPS decode definitions: opcode/funct encodings, ALU operations,
// early-branch command codes and the registered execute bundle.
package mips_decode_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [4:0] {
    ALU_NOP   = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_ADDU  = 5'd2,
    ALU_SUB   = 5'd3,
    ALU_SUBU  = 5'd4,
    ALU_AND   = 5'd5,
    ALU_OR    = 5'd6,
    ALU_XOR   = 5'd7,
    ALU_NOR   = 5'd8,
    ALU_SLT   = 5'd9,
    ALU_SLTU  = 5'd10,
    ALU_SLL   = 5'd11,
    ALU_SRL   = 5'd12,
    ALU_SRA   = 5'd13,
    ALU_LUI   = 5'd14,
    ALU_MULT  = 5'd15,
    ALU_MULTU = 5'd16,
    ALU_DIV   = 5'd17,
    ALU_DIVU  = 5'd18,
    ALU_MFHI  = 5'd19,
    ALU_MFLO  = 5'd20,
    ALU_LINK  = 5'd21
  } alu_op_e;

  typedef enum logic [3:0] {
    EB_NONE          = 4'h0,
    EB_JUMP          = 4'h1,
    EB_JUMP_LINK     = 4'h3,
    EB_PREDICT_TAKEN = 4'h4
  } eb_cmd_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    alu_op_e     alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rt_val;
    logic [4:0]  dest;
    logic        mem_rd;
    logic        mem_wr;
    logic        hilo_wr;
  } ex_bundle_t;

  function automatic logic [1:0] max2(input logic [1:0] x, input logic [1:0] y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/pipeline_decode_if.sv
// Decode-to-execute bundle; decode drives it as master, execute reads as slave.
interface pipeline_decode_if;
  import mips_decode_pkg::*;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  alu_op_e     ex_alu_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_rt_val;
  logic [4:0]  ex_dest;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic        ex_hilo_wr;

  modport master (
    output ex_valid, ex_pc, ex_inst, ex_alu_op, ex_a, ex_b, ex_rt_val,
           ex_dest, ex_mem_rd, ex_mem_wr, ex_hilo_wr
  );

  modport slave (
    input ex_valid, ex_pc, ex_inst, ex_alu_op, ex_a, ex_b, ex_rt_val,
          ex_dest, ex_mem_rd, ex_mem_wr, ex_hilo_wr
  );
endinterface

// File: rtl/pipeline_decode_inst.sv
// Pure combinational instruction decoder: fields, ALU op, source usage,
// destination, extended immediate and class flags.
module decode_inst
  import mips_decode_pkg::*;
(
  input  logic [31:0] inst_i,
  output alu_op_e     alu_op_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic        use_rs_o,
  output logic        use_rt_o,
  output logic [4:0]  dest_o,
  output logic [31:0] imm_o,
  output logic [4:0]  shamt_o,
  output logic        sel_imm_o,
  output logic        shift_imm_o,
  output logic        shift_var_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        hilo_wr_o,
  output logic        mfhilo_o,
  output logic        jump_o,
  output logic        jal_o,
  output logic        branch_o,
  output logic        defined_o
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic        zext;
  logic        lui;

  assign op      = inst_i[31:26];
  assign rs_o    = inst_i[25:21];
  assign rt_o    = inst_i[20:16];
  assign rd      = inst_i[15:11];
  assign shamt_o = inst_i[10:6];
  assign fn      = inst_i[5:0];
  assign imm16   = inst_i[15:0];

  // Immediate extension selected by instruction class
  always_comb begin
    imm_o = {{16{imm16[15]}}, imm16};
    if (lui)       imm_o = {imm16, 16'h0};
    else if (zext) imm_o = {16'h0, imm16};
  end

  // Opcode/funct decode into control flags
  always_comb begin
    alu_op_o    = ALU_NOP;
    use_rs_o    = 1'b0;
    use_rt_o    = 1'b0;
    dest_o      = '0;
    sel_imm_o   = 1'b0;
    shift_imm_o = 1'b0;
    shift_var_o = 1'b0;
    mem_rd_o    = 1'b0;
    mem_wr_o    = 1'b0;
    hilo_wr_o   = 1'b0;
    mfhilo_o    = 1'b0;
    jump_o      = 1'b0;
    jal_o       = 1'b0;
    branch_o    = 1'b0;
    defined_o   = 1'b1;
    zext        = 1'b0;
    lui         = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL, FN_SRL, FN_SRA: begin
            use_rt_o    = 1'b1;
            dest_o      = rd;
            shift_imm_o = 1'b1;
            alu_op_o    = (fn == FN_SLL) ? ALU_SLL : (fn == FN_SRL) ? ALU_SRL : ALU_SRA;
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            use_rs_o    = 1'b1;
            use_rt_o    = 1'b1;
            dest_o      = rd;
            shift_var_o = 1'b1;
            alu_op_o    = (fn == FN_SLLV) ? ALU_SLL : (fn == FN_SRLV) ? ALU_SRL : ALU_SRA;
          end
          FN_JR: use_rs_o = 1'b1;
          FN_JALR: begin
            use_rs_o = 1'b1;
            dest_o   = rd;
            alu_op_o = ALU_LINK;
          end
          FN_MFHI, FN_MFLO: begin
            dest_o   = rd;
            mfhilo_o = 1'b1;
            alu_op_o = (fn == FN_MFHI) ? ALU_MFHI : ALU_MFLO;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            use_rs_o  = 1'b1;
            use_rt_o  = 1'b1;
            hilo_wr_o = 1'b1;
            case (fn)
              FN_MULT:  alu_op_o = ALU_MULT;
              FN_MULTU: alu_op_o = ALU_MULTU;
              FN_DIV:   alu_op_o = ALU_DIV;
              default:  alu_op_o = ALU_DIVU;
            endcase
          end
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            use_rs_o = 1'b1;
            use_rt_o = 1'b1;
            dest_o   = rd;
            case (fn)
              FN_ADD:  alu_op_o = ALU_ADD;
              FN_ADDU: alu_op_o = ALU_ADDU;
              FN_SUB:  alu_op_o = ALU_SUB;
              FN_SUBU: alu_op_o = ALU_SUBU;
              FN_AND:  alu_op_o = ALU_AND;
              FN_OR:   alu_op_o = ALU_OR;
              FN_XOR:  alu_op_o = ALU_XOR;
              FN_NOR:  alu_op_o = ALU_NOR;
              FN_SLT:  alu_op_o = ALU_SLT;
              default: alu_op_o = ALU_SLTU;
            endcase
          end
          default: defined_o = 1'b0;
        endcase
      end
      OP_J: jump_o = 1'b1;
      OP_JAL: begin
        jal_o    = 1'b1;
        dest_o   = 5'd31;
        alu_op_o = ALU_LINK;
      end
      OP_BEQ, OP_BNE: begin
        branch_o = 1'b1;
        use_rs_o = 1'b1;
        use_rt_o = 1'b1;
        alu_op_o = ALU_SUBU;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        use_rs_o  = 1'b1;
        dest_o    = rt_o;
        sel_imm_o = 1'b1;
        case (op)
          OP_ADDI:  alu_op_o = ALU_ADD;
          OP_ADDIU: alu_op_o = ALU_ADDU;
          OP_SLTI:  alu_op_o = ALU_SLT;
          default:  alu_op_o = ALU_SLTU;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        use_rs_o  = 1'b1;
        dest_o    = rt_o;
        sel_imm_o = 1'b1;
        zext      = 1'b1;
        alu_op_o  = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_XOR;
      end
      OP_LUI: begin
        dest_o    = rt_o;
        sel_imm_o = 1'b1;
        lui       = 1'b1;
        alu_op_o  = ALU_LUI;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        use_rs_o  = 1'b1;
        dest_o    = rt_o;
        sel_imm_o = 1'b1;
        mem_rd_o  = 1'b1;
        alu_op_o  = ALU_ADDU;
      end
      OP_SB, OP_SH, OP_SW: begin
        use_rs_o  = 1'b1;
        use_rt_o  = 1'b1;
        sel_imm_o = 1'b1;
        mem_wr_o  = 1'b1;
        alu_op_o  = ALU_ADDU;
      end
      default: defined_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_decode.sv
// DECODE stage: selects the current instruction (fetch or hold register),
// detects load-use and HI/LO hazards, raises stall/early-branch commands to
// fetch and registers the decoded bundle towards execute.
module pipeline_decode
  import mips_decode_pkg::*;
#(
  parameter int unsigned MULDIV_LAT     = 3,
  parameter int unsigned LOAD_USE_STALL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        br_late_done,
  output logic [1:0]  stall_request,
  output logic [3:0]  early_branch_cmd,
  output logic [4:0]  rf_raddr_a,
  output logic [4:0]  rf_raddr_b,
  input  logic [31:0] rf_rdata_a,
  input  logic [31:0] rf_rdata_b,
  pipeline_decode_if.master ex
);

  ex_bundle_t  ex_q, ex_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_inst_q, hold_inst_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [1:0]  hilo_cnt_q, hilo_cnt_d;

  logic [31:0] cur_inst, cur_pc;
  alu_op_e     d_alu_op;
  logic [4:0]  d_rs, d_rt, d_dest, d_shamt;
  logic [31:0] d_imm;
  logic        d_use_rs, d_use_rt, d_sel_imm, d_shift_imm, d_shift_var;
  logic        d_mem_rd, d_mem_wr, d_hilo_wr, d_mfhilo;
  logic        d_jump, d_jal, d_branch, d_defined;
  logic        cur_live, lu_hazard, hl_hazard, hazard, issue;

  // Held instruction wins unless a late branch redirected fetch this cycle
  always_comb begin
    cur_inst = inst_in;
    cur_pc   = pc_in;
    if (hold_valid_q && !br_late_done) begin
      cur_inst = hold_inst_q;
      cur_pc   = hold_pc_q;
    end
  end

  decode_inst u_decode (
    .inst_i      (cur_inst),
    .alu_op_o    (d_alu_op),
    .rs_o        (d_rs),
    .rt_o        (d_rt),
    .use_rs_o    (d_use_rs),
    .use_rt_o    (d_use_rt),
    .dest_o      (d_dest),
    .imm_o       (d_imm),
    .shamt_o     (d_shamt),
    .sel_imm_o   (d_sel_imm),
    .shift_imm_o (d_shift_imm),
    .shift_var_o (d_shift_var),
    .mem_rd_o    (d_mem_rd),
    .mem_wr_o    (d_mem_wr),
    .hilo_wr_o   (d_hilo_wr),
    .mfhilo_o    (d_mfhilo),
    .jump_o      (d_jump),
    .jal_o       (d_jal),
    .branch_o    (d_branch),
    .defined_o   (d_defined)
  );

  assign rf_raddr_a = d_rs;
  assign rf_raddr_b = d_rt;

  assign cur_live  = (cur_inst != '0) && d_defined;
  assign lu_hazard = cur_live && ex_q.valid && ex_q.mem_rd && (ex_q.dest != '0) &&
                     ((d_use_rs && (d_rs == ex_q.dest)) || (d_use_rt && (d_rt == ex_q.dest)));
  assign hl_hazard = cur_live && d_mfhilo && (hilo_cnt_q != '0);
  assign hazard    = lu_hazard || hl_hazard;
  assign issue     = cur_live && !hazard;

  // Stall request to fetch: larger of the two hazard demands
  always_comb begin
    stall_request = max2(lu_hazard ? 2'(LOAD_USE_STALL) : 2'd0,
                         hl_hazard ? hilo_cnt_q : 2'd0);
  end

  // Early redirect only for instructions actually issuing this cycle
  always_comb begin
    early_branch_cmd = EB_NONE;
    if (issue) begin
      if (d_jump)                        early_branch_cmd = EB_JUMP;
      else if (d_jal)                    early_branch_cmd = EB_JUMP_LINK;
      else if (d_branch && cur_inst[15]) early_branch_cmd = EB_PREDICT_TAKEN;
    end
  end

  // Next-state: execute bundle, hold register and HI/LO countdown
  always_comb begin
    ex_d         = '0;
    hold_valid_d = 1'b0;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    hilo_cnt_d   = (hilo_cnt_q != '0) ? hilo_cnt_q - 2'd1 : 2'd0;
    if (hazard) begin
      hold_valid_d = 1'b1;
      hold_inst_d  = cur_inst;
      hold_pc_d    = cur_pc;
    end
    if (issue) begin
      ex_d.valid   = 1'b1;
      ex_d.pc      = cur_pc;
      ex_d.inst    = cur_inst;
      ex_d.alu_op  = d_alu_op;
      ex_d.rt_val  = rf_rdata_b;
      ex_d.dest    = d_dest;
      ex_d.mem_rd  = d_mem_rd;
      ex_d.mem_wr  = d_mem_wr;
      ex_d.hilo_wr = d_hilo_wr;
      // Shifts operate on rt; amount comes from shamt or rs
      if (d_shift_imm) begin
        ex_d.a = rf_rdata_b;
        ex_d.b = {27'h0, d_shamt};
      end else if (d_shift_var) begin
        ex_d.a = rf_rdata_b;
        ex_d.b = rf_rdata_a;
      end else if (d_jal) begin
        ex_d.a = cur_pc + 32'd8;
        ex_d.b = '0;
      end else begin
        ex_d.a = rf_rdata_a;
        ex_d.b = d_sel_imm ? d_imm : rf_rdata_b;
      end
      if (d_hilo_wr) hilo_cnt_d = 2'(MULDIV_LAT);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_inst_q  <= '0;
      hold_pc_q    <= '0;
      hilo_cnt_q   <= '0;
    end else begin
      ex_q         <= ex_d;
      hold_valid_q <= hold_valid_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      hilo_cnt_q   <= hilo_cnt_d;
    end
  end

  assign ex.ex_valid   = ex_q.valid;
  assign ex.ex_pc      = ex_q.pc;
  assign ex.ex_inst    = ex_q.inst;
  assign ex.ex_alu_op  = ex_q.alu_op;
  assign ex.ex_a       = ex_q.a;
  assign ex.ex_b       = ex_q.b;
  assign ex.ex_rt_val  = ex_q.rt_val;
  assign ex.ex_dest    = ex_q.dest;
  assign ex.ex_mem_rd  = ex_q.mem_rd;
  assign ex.ex_mem_wr  = ex_q.mem_wr;
  assign ex.ex_hilo_wr = ex_q.hilo_wr;

endmodule
